// File: rtl/bp_dstate_sched.sv
// bp_dstate_sched: backprop dstate scheduler sweeping cell slots per timestep, newest timestep first; define BP_DSTATE_SCHED_STALL_EN to honour i_stall
module bp_dstate_sched #(
   parameter int NUM_CELL   = 8,
   parameter int DELTA_TIME = 12,
   parameter int DELAY      = 20,
   parameter int TIMESTEP   = 4,
   parameter int CNT_WIDTH  = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   input  logic                 i_stall,
   output logic                 o_busy,
   output logic                 o_gen_en,
   output logic                 o_wr_en,
   output logic [CNT_WIDTH-1:0] o_cell,
   output logic [CNT_WIDTH-1:0] o_tstep,
   output logic                 o_first,
   output logic                 o_done
);
   typedef enum logic [1:0] {IDLE, CALC, DRAIN, DONE} state_t;
   localparam logic [CNT_WIDTH-1:0] SLOT_LAST  = CNT_WIDTH'(DELTA_TIME - 1);
   localparam logic [CNT_WIDTH-1:0] CELL_LAST  = CNT_WIDTH'(NUM_CELL - 1);
   localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(DELAY - 1);
   localparam logic [CNT_WIDTH-1:0] TSTEP_LAST = CNT_WIDTH'(TIMESTEP - 1);
   state_t               state, n_state;
   logic [CNT_WIDTH-1:0] cnt, n_cnt, n_cell, n_tstep;
   logic                 gen_q, wr_q, hold, n_active;
`ifdef BP_DSTATE_SCHED_STALL_EN
   assign hold = i_stall && (state == CALC || state == DRAIN);
`else
   logic stall_unused;
   assign stall_unused = i_stall;
   assign hold = 1'b0;
`endif
   assign n_active = n_state == CALC || n_state == DRAIN;
   // a stall freezes everything by simply keeping the current values
   always_comb begin
      n_state = state;
      n_cnt   = cnt;
      n_cell  = o_cell;
      n_tstep = o_tstep;
      if (!hold)
         case (state)
            IDLE: if (i_start) begin
               n_state = CALC;
               n_cnt   = '0;
               n_cell  = '0;
               n_tstep = TSTEP_LAST;
            end
            CALC: if (cnt == SLOT_LAST) begin
               n_cnt   = '0;
               n_cell  = (o_cell == CELL_LAST) ? '0 : o_cell + 1'b1;
               n_state = (o_cell == CELL_LAST) ? DRAIN : CALC;
            end else
               n_cnt = cnt + 1'b1;
            DRAIN: if (cnt == DRAIN_LAST) begin
               n_cnt   = '0;
               n_state = (o_tstep == '0) ? DONE : CALC;
               n_tstep = (o_tstep == '0) ? o_tstep : o_tstep - 1'b1;
            end else
               n_cnt = cnt + 1'b1;
            default: n_state = IDLE;
         endcase
   end
   // outputs are registered from next-state values so they line up with the state they describe
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         o_cell  <= '0;
         o_tstep <= '0;
         o_busy  <= 1'b0;
         gen_q   <= 1'b0;
         wr_q    <= 1'b0;
         o_done  <= 1'b0;
         o_first <= 1'b0;
      end else begin
         state   <= n_state;
         cnt     <= n_cnt;
         o_cell  <= n_cell;
         o_tstep <= n_tstep;
         o_busy  <= n_state != IDLE;
         gen_q   <= n_active;
         wr_q    <= n_state == CALC && n_cnt == SLOT_LAST;
         o_done  <= n_state == DONE;
         o_first <= n_active && n_tstep == TSTEP_LAST;
      end
   assign o_gen_en = gen_q & ~hold;
   assign o_wr_en  = wr_q & ~hold;
endmodule

// File: tb/tb_bp_dstate_sched.sv
// tb_bp_dstate_sched: directed checks of bp_dstate_sched with default parameters
module tb_bp_dstate_sched;
   logic        clk = 1'b0, rst = 1'b0, i_start = 1'b0, i_stall = 1'b0;
   logic        o_busy, o_gen_en, o_wr_en, o_first, o_done;
   logic [11:0] o_cell, o_tstep;
   int          compared = 0, mismatched = 0, wr_cnt = 0, gen_cnt = 0;

   bp_dstate_sched dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_stall(i_stall),
      .o_busy(o_busy), .o_gen_en(o_gen_en), .o_wr_en(o_wr_en),
      .o_cell(o_cell), .o_tstep(o_tstep), .o_first(o_first), .o_done(o_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".busy"}, o_busy, 0);
      chk({tag, ".gen_en"}, o_gen_en, 0);
      chk({tag, ".wr_en"}, o_wr_en, 0);
      chk({tag, ".done"}, o_done, 0);
      chk({tag, ".first"}, o_first, 0);
      chk({tag, ".cell"}, o_cell, 0);
      chk({tag, ".tstep"}, o_tstep, 0);
   endtask

   // cycle c of a pass started by a pulse at cycle 0: 116 cycles per timestep, 96 of them cell slots
   task automatic check_cycle(input int c);
      int p, ts;
      bit in_pass;
      p = (c - 1) % 116;
      ts = 3 - (c - 1) / 116;
      in_pass = c >= 1 && c <= 464;
      chk($sformatf("busy@%0d", c), o_busy, c <= 465);
      chk($sformatf("gen_en@%0d", c), o_gen_en, in_pass);
      chk($sformatf("wr_en@%0d", c), o_wr_en, in_pass && p < 96 && p % 12 == 11);
      chk($sformatf("cell@%0d", c), o_cell, (in_pass && p < 96) ? p / 12 : 0);
      chk($sformatf("tstep@%0d", c), o_tstep, in_pass ? ts : 0);
      chk($sformatf("first@%0d", c), o_first, c <= 116);
      chk($sformatf("done@%0d", c), o_done, c == 465);
   endtask

   // start pulse at cycle 0; start re-pulsed at 50 and in DONE, stall toggled (ignored in default build)
   task automatic run_pass(input int last);
      i_start = 1'b1;
      step;
      i_start = 1'b0;
      wr_cnt = 0;
      gen_cnt = 0;
      for (int c = 1; c <= last; c++) begin
         check_cycle(c);
         wr_cnt += int'(o_wr_en);
         gen_cnt += int'(o_gen_en);
         i_start = (c == 50 || c == 465);
         i_stall = (c >= 30 && c <= 34);
         if (c < last) step;
      end
      i_start = 1'b0;
      i_stall = 1'b0;
   endtask

   initial begin
      step;
      step;
      chk_reset("por");
      @(negedge clk);
      rst = 1'b1;
      step;
      chk_reset("idle");
      run_pass(470);
      chk("pass1.wr_pulses", wr_cnt, 32);
      chk("pass1.gen_cycles", gen_cnt, 464);
      run_pass(200);
      #2;
      rst = 1'b0;
      #1;
      chk_reset("async_rst");
      for (int i = 0; i < 3; i++) begin
         step;
         chk_reset($sformatf("rst_hold%0d", i));
      end
      @(negedge clk);
      rst = 1'b1;
      step;
      chk_reset("post_rst");
      run_pass(470);
      chk("pass3.wr_pulses", wr_cnt, 32);
      chk("pass3.gen_cycles", gen_cnt, 464);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
